irq_vector_unit: RTL and testbench

Parametrised interrupt and vector controller for the 65xx core, generalising the single IRQ/NMI pair into N_CH prioritised channels. Channel 0 is non-maskable; channels 1..N_CH-1 are maskable and configurable per channel as edge- or level-sensitive. The block samples requests at CPU-defined points, raises `int_req` toward the sequencer, and supplies a registered 16-bit vector address on acknowledge. It sits between peripheral interrupt lines and the CPU top's interrupt-recognition and vector-fetch logic. It also has a small register port for enable, mode, pending and in-service state.

---
 rtl/irq_vector_unit_if.sv | 23 ++
 rtl/irq_vector_unit.sv | 112 +++++++++++
 tb/tb_irq_vector_unit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_vector_unit_if.sv
// CPU-side bundle of the interrupt/vector unit: recognition handshake, vector result and register port.
interface irq_vector_unit_if;
    logic        cpu_sample;
    logic        cpu_imask;
    logic        cpu_ack;
    logic        int_req;
    logic [15:0] vec_addr;
    logic        vec_hw;
    logic        reg_we;
    logic [1:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;

    modport master (
        output cpu_sample, cpu_imask, cpu_ack, reg_we, reg_addr, reg_wdata,
        input  int_req, vec_addr, vec_hw, reg_rdata
    );

    modport slave (
        input  cpu_sample, cpu_imask, cpu_ack, reg_we, reg_addr, reg_wdata,
        output int_req, vec_addr, vec_hw, reg_rdata
    );
endinterface

// File: rtl/irq_vector_unit.sv
// Prioritised N_CH-channel interrupt/vector controller for the 65xx core (channel 0 = NMI).
// irq_in -> int_req in 3 edges minimum; vector registered on ack; no backpressure, the CPU paces via sample/ack.
module irq_vector_unit #(
    parameter int          N_CH      = 8,
    parameter logic [15:0] VEC_RESET = 16'hFFFC,
    parameter logic [15:0] VEC_NMI   = 16'hFFFA,
    parameter logic [15:0] VEC_BRK   = 16'hFFFE,
    parameter logic [15:0] VEC_BASE  = 16'hFFE0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] irq_in,
    irq_vector_unit_if.slave bus
);
    localparam logic [N_CH-1:0] CH0_MASK = {{(N_CH-1){1'b0}}, 1'b1};

    logic [N_CH-1:0] sync_q, prev_q;
    logic [N_CH-1:0] en_q, mode_q, pend_q, isr_q;
    logic            rst_flag_q;

    logic [N_CH-1:0] rise, en_eff, elig;
    logic [N_CH-1:0] grant_oh, w1c_pend, w1c_isr, pend_nxt, isr_nxt;
    logic            win_vld, blk;
    logic [2:0]      win_idx;
    logic [15:0]     win_vec;

    assign rise   = sync_q & ~prev_q;
    assign en_eff = en_q | CH0_MASK;

    // In-service at any index <= c blocks channel c; NMI ignores in-service entirely.
    always_comb begin
        blk     = 1'b0;
        elig    = '0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int c = 0; c < N_CH; c++) begin
            blk = blk | isr_q[c];
            if (c == 0)
                elig[c] = pend_q[c];
            else
                elig[c] = pend_q[c] & en_eff[c] & ~bus.cpu_imask & ~blk;
        end
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (elig[c]) begin
                win_vld = 1'b1;
                win_idx = 3'(c);
            end
        end
    end

    assign win_vec  = (win_idx == 3'd0) ? VEC_NMI : VEC_BASE + {12'd0, win_idx, 1'b0};
    assign grant_oh = (bus.cpu_ack && !rst_flag_q && win_vld) ? (CH0_MASK << win_idx) : '0;
    assign w1c_pend = (bus.reg_we && bus.reg_addr == 2'd2) ? bus.reg_wdata[N_CH-1:0] : '0;
    assign w1c_isr  = (bus.reg_we && bus.reg_addr == 2'd3) ? bus.reg_wdata[N_CH-1:0] : '0;

    // Edge channels: a fresh rise beats any clear; level channels just track the synchroniser.
    assign pend_nxt = (mode_q & (rise | (pend_q & ~(grant_oh | w1c_pend)))) | (~mode_q & sync_q);
    assign isr_nxt  = (isr_q & ~w1c_isr) | grant_oh;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= '0;
            prev_q       <= '0;
            en_q         <= '0;
            mode_q       <= '1;
            pend_q       <= '0;
            isr_q        <= '0;
            rst_flag_q   <= 1'b1;
            bus.int_req  <= 1'b1;
            bus.vec_addr <= VEC_RESET;
            bus.vec_hw   <= 1'b1;
        end else begin
            sync_q <= irq_in;
            prev_q <= sync_q;
            pend_q <= pend_nxt;
            isr_q  <= isr_nxt;
            if (bus.reg_we && bus.reg_addr == 2'd0)
                en_q <= bus.reg_wdata[N_CH-1:0];
            if (bus.reg_we && bus.reg_addr == 2'd1)
                mode_q <= bus.reg_wdata[N_CH-1:0] | CH0_MASK;

            if (bus.cpu_ack)
                bus.int_req <= 1'b0;
            else if (bus.cpu_sample)
                bus.int_req <= rst_flag_q | win_vld;

            if (bus.cpu_ack) begin
                if (rst_flag_q) begin
                    bus.vec_addr <= VEC_RESET;
                    bus.vec_hw   <= 1'b1;
                    rst_flag_q   <= 1'b0;
                end else if (win_vld) begin
                    bus.vec_addr <= win_vec;
                    bus.vec_hw   <= 1'b1;
                end else begin
                    bus.vec_addr <= VEC_BRK;
                    bus.vec_hw   <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.reg_rdata = '0;
        case (bus.reg_addr)
            2'd0:    bus.reg_rdata[N_CH-1:0] = en_eff;
            2'd1:    bus.reg_rdata[N_CH-1:0] = mode_q;
            2'd2:    bus.reg_rdata[N_CH-1:0] = pend_q;
            default: bus.reg_rdata[N_CH-1:0] = isr_q;
        endcase
    end
endmodule

// File: tb/tb_irq_vector_unit.sv
// Directed and random checks of irq_vector_unit against a channel-level reference model.
module tb_irq_vector_unit;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_in;

    irq_vector_unit_if bus();

    irq_vector_unit #(.N_CH(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .irq_in (irq_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference state, one entry per channel.
    bit          m_sync [N];
    bit          m_prev [N];
    bit          m_pend [N];
    bit          m_en   [N];
    bit          m_mode [N];
    bit          m_isr  [N];
    bit          m_flag, m_req, m_hw;
    logic [15:0] m_vec;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_sync[c] = 0; m_prev[c] = 0; m_pend[c] = 0;
            m_en[c]   = 0; m_mode[c] = 1; m_isr[c]  = 0;
        end
        m_flag = 1; m_req = 1; m_hw = 1; m_vec = 16'hFFFC;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int  w;
        int  grant;
        bit  blocked;
        bit  rise;
        bit  cleared;
        if (reset) begin
            model_reset();
        end else begin
            w = -1;
            blocked = 0;
            for (int c = 0; c < N; c++) begin
                blocked = blocked | m_isr[c];
                if (w < 0 && m_pend[c] &&
                    (c == 0 || (m_en[c] && !bus.cpu_imask && !blocked)))
                    w = c;
            end
            if (bus.cpu_ack)
                m_req = 0;
            else if (bus.cpu_sample)
                m_req = m_flag || (w >= 0);
            grant = -1;
            if (bus.cpu_ack) begin
                if (m_flag) begin
                    m_vec = 16'hFFFC; m_hw = 1; m_flag = 0;
                end else if (w >= 0) begin
                    m_vec = (w == 0) ? 16'hFFFA : 16'(32'hFFE0 + 2 * w);
                    m_hw  = 1;
                    grant = w;
                end else begin
                    m_vec = 16'hFFFE; m_hw = 0;
                end
            end
            for (int c = 0; c < N; c++) begin
                rise = m_sync[c] && !m_prev[c];
                if (c == 0 || m_mode[c]) begin
                    cleared = (c == grant) ||
                              (bus.reg_we && bus.reg_addr == 2'd2 && bus.reg_wdata[c]);
                    m_pend[c] = rise || (m_pend[c] && !cleared);
                end else begin
                    m_pend[c] = m_sync[c];
                end
                if (bus.reg_we && bus.reg_addr == 2'd3 && bus.reg_wdata[c]) m_isr[c] = 0;
                if (c == grant) m_isr[c] = 1;
                if (c > 0 && bus.reg_we && bus.reg_addr == 2'd0) m_en[c]   = bus.reg_wdata[c];
                if (c > 0 && bus.reg_we && bus.reg_addr == 2'd1) m_mode[c] = bus.reg_wdata[c];
                m_prev[c] = m_sync[c];
                m_sync[c] = irq_in[c];
            end
        end
    endtask

    function automatic logic [7:0] exp_rdata(input logic [1:0] a);
        logic [7:0] r;
        r = '0;
        for (int c = 0; c < N; c++) begin
            case (a)
                2'd0:    r[c] = (c == 0) || m_en[c];
                2'd1:    r[c] = m_mode[c];
                2'd2:    r[c] = m_pend[c];
                default: r[c] = m_isr[c];
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("int_req",   16'(bus.int_req),   16'(m_req));
        chk("vec_addr",  bus.vec_addr,       m_vec);
        chk("vec_hw",    16'(bus.vec_hw),    16'(m_hw));
        chk("reg_rdata", 16'(bus.reg_rdata), 16'(exp_rdata(bus.reg_addr)));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.reg_we = 1; bus.reg_addr = a; bus.reg_wdata = d;
        tick();
        bus.reg_we = 0;
    endtask

    task automatic ack_pulse();
        bus.cpu_ack = 1;
        tick();
        bus.cpu_ack = 0;
    endtask

    task automatic peek(input string tag, input logic [1:0] a, input logic [7:0] exp);
        bus.reg_addr = a;
        #1;
        chk(tag, 16'(bus.reg_rdata), 16'(exp));
    endtask

    initial begin
        reset = 1; irq_in = '0;
        bus.cpu_sample = 0; bus.cpu_imask = 0; bus.cpu_ack = 0;
        bus.reg_we = 0; bus.reg_addr = 0; bus.reg_wdata = 0;
        model_reset();
        tick(); tick();
        chk("rst_int_req", 16'(bus.int_req), 16'd1);
        chk("rst_vec", bus.vec_addr, 16'hFFFC);
        peek("rst_en", 2'd0, 8'h01);
        peek("rst_mode", 2'd1, 8'hFF);

        // Reset vector handshake
        reset = 0; bus.cpu_sample = 1;
        tick();
        chk("flag_req", 16'(bus.int_req), 16'd1);
        ack_pulse();
        chk("rst_ack_vec", bus.vec_addr, 16'hFFFC);
        chk("rst_ack_hw", 16'(bus.vec_hw), 16'd1);
        chk("rst_ack_req", 16'(bus.int_req), 16'd0);
        tick();
        chk("post_rst_req", 16'(bus.int_req), 16'd0);

        // Edge channel 2 latency and vector
        wr(2'd0, 8'h06); wr(2'd1, 8'h06);
        irq_in = 8'h04; tick();
        irq_in = 8'h00; tick();
        chk("lat2_req", 16'(bus.int_req), 16'd0);
        tick();
        chk("lat3_req", 16'(bus.int_req), 16'd1);
        ack_pulse();
        chk("ch2_vec", bus.vec_addr, 16'hFFE4);
        peek("ch2_pend", 2'd2, 8'h00);
        peek("ch2_isr", 2'd3, 8'h04);

        // In-service blocking of higher-index channel
        wr(2'd3, 8'hFF); wr(2'd0, 8'h0A); wr(2'd1, 8'h0A);
        irq_in = 8'h02; tick();
        irq_in = 8'h00; tick(); tick();
        ack_pulse();
        chk("ch1_vec", bus.vec_addr, 16'hFFE2);
        irq_in = 8'h08; tick();
        irq_in = 8'h00; tick(); tick(); tick();
        chk("blocked_req", 16'(bus.int_req), 16'd0);
        peek("blocked_pend", 2'd2, 8'h08);
        wr(2'd3, 8'h02);
        tick();
        chk("unblocked_req", 16'(bus.int_req), 16'd1);
        ack_pulse();
        chk("ch3_vec", bus.vec_addr, 16'hFFE6);

        // NMI under I mask, level channel 1 held
        wr(2'd3, 8'hFF); bus.cpu_imask = 1;
        wr(2'd1, 8'h08); wr(2'd0, 8'h0A);
        irq_in = 8'h03; tick();
        irq_in = 8'h02; tick(); tick();
        ack_pulse();
        chk("nmi_vec", bus.vec_addr, 16'hFFFA);
        peek("nmi_pend", 2'd2, 8'h02);

        // Level request withdrawn before ack
        wr(2'd3, 8'hFF); bus.cpu_imask = 0;
        tick(); tick();
        chk("lvl_req", 16'(bus.int_req), 16'd1);
        bus.cpu_sample = 0; irq_in = 8'h00;
        tick(); tick(); tick();
        ack_pulse();
        chk("brk_vec", bus.vec_addr, 16'hFFFE);
        chk("brk_hw", 16'(bus.vec_hw), 16'd0);
        peek("brk_isr", 2'd3, 8'h00);
        bus.cpu_sample = 1;

        // Rise colliding with W1C and with ack
        wr(2'd1, 8'hFE); wr(2'd0, 8'h02);
        irq_in = 8'h02; tick();
        irq_in = 8'h00; tick();
        irq_in = 8'h02; tick();
        irq_in = 8'h00;
        bus.reg_we = 1; bus.reg_addr = 2'd2; bus.reg_wdata = 8'h02;
        tick();
        bus.reg_we = 0;
        peek("w1c_vs_rise", 2'd2, 8'h02);
        wr(2'd2, 8'h02);
        peek("w1c_clear", 2'd2, 8'h00);
        irq_in = 8'h02; tick();
        irq_in = 8'h00; tick();
        irq_in = 8'h02; tick();
        irq_in = 8'h00;
        ack_pulse();
        chk("ack_vs_rise_vec", bus.vec_addr, 16'hFFE2);
        peek("ack_vs_rise_pend", 2'd2, 8'h02);
        peek("ack_vs_rise_isr", 2'd3, 8'h02);

        // Random traffic, occasional mid-sequence reset
        wr(2'd3, 8'hFF);
        for (int i = 0; i < 1500; i++) begin
            irq_in         = N'($urandom);
            bus.cpu_sample = ($urandom % 2) == 0;
            bus.cpu_imask  = ($urandom % 4) == 0;
            bus.cpu_ack    = ($urandom % 6) == 0;
            bus.reg_we     = ($urandom % 5) == 0;
            bus.reg_addr   = 2'($urandom);
            bus.reg_wdata  = 8'($urandom);
            reset          = ($urandom % 200) == 0;
            tick();
        end
        reset = 0; bus.cpu_ack = 0; bus.reg_we = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
